// File: rtl/memory_pkg.sv
// Memory stage shared types: access sizes, writeback selects,
// exception causes and the bus FSM state.
package memory_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  localparam logic [1:0] WS_ALU  = 2'd0;
  localparam logic [1:0] WS_LOAD = 2'd1;
  localparam logic [1:0] WS_CSR  = 2'd2;
  localparam logic [1:0] WS_PC4  = 2'd3;

  localparam logic [3:0] ECAUSE_ILLEGAL   = 4'd2;
  localparam logic [3:0] ECAUSE_LD_MISAL  = 4'd4;
  localparam logic [3:0] ECAUSE_LD_FAULT  = 4'd5;
  localparam logic [3:0] ECAUSE_ST_MISAL  = 4'd6;
  localparam logic [3:0] ECAUSE_ST_FAULT  = 4'd7;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic [1:0] off;
    size_e      size;
    logic       sgn;
    logic       store;
  } acc_t;

endpackage

// File: rtl/memory_if.sv
// Data bus between the memory stage and the memory system.
interface memory_if;
  logic        mem_req;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_store_data;
  logic [3:0]  mem_byte_enable;
  logic        mem_ready;
  logic [31:0] mem_load_data;
  logic        mem_error;

  modport master (
    output mem_req, mem_write, mem_address,
    output mem_store_data, mem_byte_enable,
    input  mem_ready, mem_load_data, mem_error
  );

  modport slave (
    input  mem_req, mem_write, mem_address,
    input  mem_store_data, mem_byte_enable,
    output mem_ready, mem_load_data, mem_error
  );
endinterface

// File: rtl/memory_load_align.sv
// Load lane select and sign/zero extension.
module load_align
  import memory_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  offset,
  input  size_e       size,
  input  logic        sgn,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = data[{offset, 3'b000} +: 8];
    h = offset[1] ? data[31:16] : data[15:0];
    result = data;
    unique case (1'b1)
      size == SIZE_BYTE: result = {{24{sgn & b[7]}}, b};
      size == SIZE_HALF: result = {{16{sgn & h[15]}}, h};
      default:           result = data;
    endcase
  end

endmodule

// File: rtl/memory.sv
// Memory pipeline stage: issues loads/stores on the data bus
// and registers the writeback bundle.
module memory
  import memory_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc_in,
  input  logic [31:0] next_pc_in,
  input  logic [31:0] alu_data_in,
  input  logic [31:0] rs2_data_in,
  input  logic [31:0] csr_data_in,
  input  logic        load_in,
  input  logic        store_in,
  input  logic        load_signed_in,
  input  logic [1:0]  load_store_size_in,
  input  logic [1:0]  write_select_in,
  input  logic [4:0]  rd_address_in,
  input  logic [11:0] csr_address_in,
  input  logic        csr_write_in,
  input  logic        mret_in,
  input  logic        wfi_in,
  input  logic        valid_in,
  input  logic        exception_in,
  input  logic [3:0]  ecause_in,
  input  logic        stall,
  input  logic        invalidate,
  memory_if.master    bus,
  output logic        mem_busy,
  output logic [31:0] pc_out,
  output logic [31:0] next_pc_out,
  output logic [31:0] alu_data_out,
  output logic [31:0] csr_data_out,
  output logic [1:0]  write_select_out,
  output logic [4:0]  rd_address_out,
  output logic [11:0] csr_address_out,
  output logic        csr_write_out,
  output logic        mret_out,
  output logic        wfi_out,
  output logic [31:0] load_data_out,
  output logic        valid_out,
  output logic        exception_out,
  output logic [3:0]  ecause_out
);

  state_e      state;
  acc_t        acc_q;
  logic        killed;
  size_e       size;
  logic [1:0]  a;
  logic        ls;
  logic        mis;
  logic        mis_exc;
  logic        start;
  logic        done;
  logic        wb_en;
  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic [31:0] ld_data;

  assign size = size_e'(load_store_size_in);
  assign a    = alu_data_in[1:0];
  assign ls   = load_in | store_in;

  always_comb begin
    mis     = 1'b0;
    st_data = rs2_data_in;
    st_be   = 4'b1111;
    unique case (1'b1)
      size == SIZE_BYTE: begin
        st_data = {4{rs2_data_in[7:0]}};
        st_be   = 4'b0001 << a;
      end
      size == SIZE_HALF: begin
        mis     = a[0];
        st_data = {2{rs2_data_in[15:0]}};
        st_be   = 4'b0011 << {a[1], 1'b0};
      end
      default: mis = (size == SIZE_WORD) && (a != 2'b00);
    endcase
  end

  assign mis_exc = valid_in & ~exception_in & ls & mis;
  assign start   = valid_in & ~exception_in & ls & ~mis & ~invalidate;
  assign done    = (state == WAIT) & bus.mem_ready;
  assign wb_en   = ((state == IDLE) & ~start & ~stall) | done;

  assign mem_busy = reset_n &
                    (((state == IDLE) & start) |
                     ((state == WAIT) & ~bus.mem_ready));

  load_align u_load_align (
    .data   (bus.mem_load_data),
    .offset (acc_q.off),
    .size   (acc_q.size),
    .sgn    (acc_q.sgn),
    .result (ld_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state               <= IDLE;
      acc_q               <= '0;
      killed              <= 1'b0;
      bus.mem_req         <= 1'b0;
      bus.mem_write       <= 1'b0;
      bus.mem_address     <= '0;
      bus.mem_store_data  <= '0;
      bus.mem_byte_enable <= '0;
      load_data_out       <= '0;
      valid_out           <= 1'b0;
      exception_out       <= 1'b0;
      ecause_out          <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            bus.mem_req         <= 1'b1;
            bus.mem_write       <= store_in;
            bus.mem_address     <= {alu_data_in[31:2], 2'b00};
            bus.mem_store_data  <= st_data;
            bus.mem_byte_enable <= st_be;
            acc_q  <= '{off: a, size: size,
                        sgn: load_signed_in, store: store_in};
            killed <= 1'b0;
            state  <= WAIT;
            if (!stall) valid_out <= 1'b0;
          end else if (!stall) begin
            valid_out     <= valid_in & ~invalidate;
            exception_out <= ~invalidate & (exception_in | mis_exc);
            load_data_out <= '0;
            ecause_out    <= exception_in ? ecause_in :
                             !mis_exc     ? 4'd0 :
                             store_in     ? ECAUSE_ST_MISAL :
                                            ECAUSE_LD_MISAL;
          end
        end
        WAIT: begin
          if (bus.mem_ready) begin
            bus.mem_req   <= 1'b0;
            state         <= IDLE;
            valid_out     <= ~(killed | invalidate);
            exception_out <= bus.mem_error & ~(killed | invalidate);
            ecause_out    <= !bus.mem_error ? 4'd0 :
                             acc_q.store    ? ECAUSE_ST_FAULT :
                                              ECAUSE_LD_FAULT;
            load_data_out <= (bus.mem_error | acc_q.store) ? '0 : ld_data;
          end else begin
            // A flush mid-transaction lets the bus finish but drops the result.
            if (invalidate) killed <= 1'b1;
            if (!stall) valid_out <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_out           <= '0;
      next_pc_out      <= '0;
      alu_data_out     <= '0;
      csr_data_out     <= '0;
      write_select_out <= '0;
      rd_address_out   <= '0;
      csr_address_out  <= '0;
      csr_write_out    <= 1'b0;
      mret_out         <= 1'b0;
      wfi_out          <= 1'b0;
    end else if (wb_en) begin
      pc_out           <= pc_in;
      next_pc_out      <= next_pc_in;
      alu_data_out     <= alu_data_in;
      csr_data_out     <= csr_data_in;
      write_select_out <= write_select_in;
      rd_address_out   <= rd_address_in;
      csr_address_out  <= csr_address_in;
      csr_write_out    <= csr_write_in;
      mret_out         <= mret_in;
      wfi_out          <= wfi_in;
    end
  end

endmodule
